readout_seq_counters: RTL and testbench

- Counter/delay core for the CFEB readout controller.
- Contains three independent sub-functions on one clock:
  - a 4-bit channel counter with Gray and binary outputs and terminal count;
  - a 3-bit Gray SCA-sample counter that runs up or down depending on block parity;
  - a clock-enabled fixed-depth delay line.
- The readout FSM uses it to sequence channels and samples and to delay L1A-pending bits.

---
 rtl/readout_seq_counters.sv | 99 +++++++++
 tb/tb_readout_seq_counters.sv | 118 +++++++++++
 2 files changed

// File: rtl/readout_seq_counters.sv
// Counter and delay core for the CFEB readout controller: a channel counter, a
// Gray-coded up/down SCA-sample counter and a clock-enabled delay line.
module readout_seq_counters #(
    parameter int TMR       = 0,
    parameter int DLY_DEPTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CH_CLR,
    input  logic       CH_CE,
    output logic [3:0] CH_GRAY,
    output logic [3:0] CH_BIN,
    output logic       CH_TC,
    input  logic       SMP_CE,
    input  logic       SMP_START,
    input  logic       UPSIE,
    output logic [2:0] SMP,
    output logic       SMP_END,
    input  logic       DLY_CE,
    input  logic       DLY_I,
    output logic       DLY_O
);

    localparam int NC = (TMR != 0) ? 3 : 1;

    logic [3:0]           b, b_nxt;
    logic [2:0]           g, g_nxt;
    logic [DLY_DEPTH-1:0] d, d_nxt;

    logic [3:0]           b_r [NC];
    logic [2:0]           g_r [NC];
    logic [DLY_DEPTH-1:0] d_r [NC];

    logic [2:0] smp_idx, smp_idx_nxt;

    // Channel counter next state: clear beats count enable.
    always_comb begin
        b_nxt = b;
        if (CH_CLR)
            b_nxt = 4'd0;
        else if (CH_CE)
            b_nxt = b + 4'd1;
    end

    // Sample counter steps in index space; Gray is converted in and out.
    always_comb begin
        smp_idx     = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
        smp_idx_nxt = smp_idx;
        g_nxt       = g;
        if (SMP_START) begin
            g_nxt = UPSIE ? 3'b000 : 3'b100;
        end else if (SMP_CE) begin
            smp_idx_nxt = UPSIE ? smp_idx + 3'd1 : smp_idx - 3'd1;
            g_nxt       = smp_idx_nxt ^ (smp_idx_nxt >> 1);
        end
    end

    always_comb begin
        d_nxt = d;
        if (DLY_CE) begin
            d_nxt[0] = DLY_I;
            for (int k = 1; k < DLY_DEPTH; k++)
                d_nxt[k] = d[k-1];
        end
    end

    for (genvar i = 0; i < NC; i++) begin : g_copy
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                b_r[i] <= '0;
                g_r[i] <= '0;
                d_r[i] <= '0;
            end else begin
                b_r[i] <= b_nxt;
                g_r[i] <= g_nxt;
                d_r[i] <= d_nxt;
            end
        end
    end

    // Every copy reloads from the voted value, so a single upset is scrubbed next edge.
    if (NC == 3) begin : g_vote
        assign b = (b_r[0] & b_r[1]) | (b_r[0] & b_r[2]) | (b_r[1] & b_r[2]);
        assign g = (g_r[0] & g_r[1]) | (g_r[0] & g_r[2]) | (g_r[1] & g_r[2]);
        assign d = (d_r[0] & d_r[1]) | (d_r[0] & d_r[2]) | (d_r[1] & d_r[2]);
    end else begin : g_single
        assign b = b_r[0];
        assign g = g_r[0];
        assign d = d_r[0];
    end

    assign CH_BIN  = b;
    assign CH_GRAY = b ^ (b >> 1);
    assign CH_TC   = (b == 4'd15);
    assign SMP     = g;
    assign SMP_END = (UPSIE & (g == 3'b100)) | (!UPSIE & (g == 3'b000));
    assign DLY_O   = d[DLY_DEPTH-1];

endmodule

// File: tb/tb_readout_seq_counters.sv
// Randomized bench: plain and TMR instances share stimulus and are both
// compared against a table/queue based reference model.
module tb_readout_seq_counters;

    localparam int D = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic CH_CLR = 0, CH_CE = 0, SMP_CE = 0, SMP_START = 0, UPSIE = 1;
    logic DLY_CE = 0, DLY_I = 0;

    logic [3:0] ch_gray [2];
    logic [3:0] ch_bin  [2];
    logic       ch_tc   [2];
    logic [2:0] smp     [2];
    logic       smp_end [2];
    logic       dly_o   [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    readout_seq_counters #(.TMR(0), .DLY_DEPTH(D)) dut0 (
        .CLK(CLK), .RST(RST), .CH_CLR(CH_CLR), .CH_CE(CH_CE),
        .CH_GRAY(ch_gray[0]), .CH_BIN(ch_bin[0]), .CH_TC(ch_tc[0]),
        .SMP_CE(SMP_CE), .SMP_START(SMP_START), .UPSIE(UPSIE),
        .SMP(smp[0]), .SMP_END(smp_end[0]),
        .DLY_CE(DLY_CE), .DLY_I(DLY_I), .DLY_O(dly_o[0])
    );

    readout_seq_counters #(.TMR(1), .DLY_DEPTH(D)) dut1 (
        .CLK(CLK), .RST(RST), .CH_CLR(CH_CLR), .CH_CE(CH_CE),
        .CH_GRAY(ch_gray[1]), .CH_BIN(ch_bin[1]), .CH_TC(ch_tc[1]),
        .SMP_CE(SMP_CE), .SMP_START(SMP_START), .UPSIE(UPSIE),
        .SMP(smp[1]), .SMP_END(smp_end[1]),
        .DLY_CE(DLY_CE), .DLY_I(DLY_I), .DLY_O(dly_o[1])
    );

    // Reference model: channel number, sample index, and a queue of past enabled inputs.
    logic [3:0] ch_gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [2:0] smp_gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                 3'b110, 3'b111, 3'b101, 3'b100};
    int ch_m;
    int si_m;
    bit dq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        ch_m = 0;
        si_m = 0;
        dq.delete();
        for (int k = 0; k < D; k++) dq.push_back(1'b0);
    endtask

    task automatic model_edge();
        if (CH_CLR)      ch_m = 0;
        else if (CH_CE)  ch_m = (ch_m + 1) % 16;
        if (SMP_START)   si_m = UPSIE ? 0 : 7;
        else if (SMP_CE) si_m = UPSIE ? (si_m + 1) % 8 : (si_m + 7) % 8;
        if (DLY_CE) begin
            dq.push_back(DLY_I);
            void'(dq.pop_front());
        end
    endtask

    task automatic check_all();
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("ch_bin%0d", u),  ch_bin[u],  ch_m);
            chk($sformatf("ch_gray%0d", u), ch_gray[u], ch_gtab[ch_m]);
            chk($sformatf("ch_tc%0d", u),   ch_tc[u],   ch_m == 15);
            chk($sformatf("smp%0d", u),     smp[u],     smp_gtab[si_m]);
            chk($sformatf("smp_end%0d", u), smp_end[u], UPSIE ? (si_m == 7) : (si_m == 0));
            chk($sformatf("dly_o%0d", u),   dly_o[u],   dq[0]);
        end
    endtask

    initial begin
        model_reset();
        #12 check_all();
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int it = 0; it < 3000; it++) begin
            CH_CLR    = ($urandom % 16) == 0;
            CH_CE     = ($urandom % 4) != 0;
            SMP_START = ($urandom % 12) == 0;
            SMP_CE    = ($urandom % 3) != 0;
            if (($urandom % 16) == 0) UPSIE = ~UPSIE;
            DLY_CE    = ($urandom % 4) != 0;
            DLY_I     = ($urandom % 3) == 0;
            #1 check_all();
            if (it % 500 == 250) begin
                // Reset between edges must clear outputs without a clock.
                #2 RST = 1'b1;
                #1 model_reset();
                check_all();
                @(posedge CLK);
                #1 RST = 1'b0;
                check_all();
            end else begin
                @(posedge CLK);
                model_edge();
                #1;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
